// File: rtl/scnn_ip_stream_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : scnn_ip_stream_compressor
//  Purpose  : Streaming input-activation compressor for a multi-PE array.
//             Accepts one dense activation per cycle, splits the frame into
//             NUM_SLICES contiguous slices and packs each slice's non-zero
//             values with their global indices. The compressed frame is held
//             stable until the consumer acknowledges it.
//  Ports    : clk, rst            - clock, async active-high reset
//             in_valid/in_ready   - dense input handshake
//             in_data, in_last    - activation value, early end-of-frame
//             out_valid/out_ack   - compressed frame handshake
//             compressed_ips      - packed non-zero values per slice
//             comp_inds_ips       - global index of each packed value
//             nzips_per_slice     - non-zero count per slice
//             offset_array        - constant slice base index (s*SLICE)
//             num_nz_ips          - total non-zeros in the frame
//             frame_len           - activations accepted in the frame
//  Revision : 1.0 - initial release
// ============================================================================
module scnn_ip_stream_compressor #(
   parameter  int NUM_ACTS   = 64,
   parameter  int NUM_SLICES = 4,
   parameter  int DATA_W     = 16,
   parameter  int IDX_W      = 8,
   localparam int SLICE      = NUM_ACTS / NUM_SLICES
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [DATA_W-1:0]                         in_data,
   input  logic                                      in_last,
   output logic                                      out_valid,
   input  logic                                      out_ack,
   output logic [NUM_SLICES-1:0][SLICE-1:0][DATA_W-1:0] compressed_ips,
   output logic [NUM_SLICES-1:0][SLICE-1:0][IDX_W-1:0]  comp_inds_ips,
   output logic [NUM_SLICES-1:0][IDX_W-1:0]          nzips_per_slice,
   output logic [NUM_SLICES-1:0][IDX_W-1:0]          offset_array,
   output logic [IDX_W-1:0]                          num_nz_ips,
   output logic [IDX_W-1:0]                          frame_len
);

   localparam int             SLICE_W = $clog2(SLICE);
   localparam int             SEL_W   = $clog2(NUM_SLICES);
   localparam logic [IDX_W-1:0] C_ONE    = IDX_W'(1);
   localparam logic [IDX_W-1:0] C_LASTPOS = IDX_W'(NUM_ACTS - 1);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t                                     state_q;
   logic                                       in_ready_q;
   logic                                       out_valid_q;
   logic [IDX_W-1:0]                           pos_q;
   logic [NUM_SLICES-1:0][SLICE-1:0][DATA_W-1:0] comp_q;
   logic [NUM_SLICES-1:0][SLICE-1:0][IDX_W-1:0]  inds_q;
   logic [NUM_SLICES-1:0][IDX_W-1:0]           nz_q;
   logic [IDX_W-1:0]                           tot_q;
   logic [IDX_W-1:0]                           flen_q;

   // Slice selected by the current position and the next free slot in it.
   // A slice can never hold more than SLICE entries, so the slot index only
   // needs the low SLICE_W bits of the count.
   logic [SEL_W-1:0]   w_slice;
   logic [SLICE_W-1:0] w_slot;
   logic [IDX_W-1:0]   w_nz_cur;

   assign w_slice  = pos_q[SLICE_W +: SEL_W];
   assign w_nz_cur = nz_q[w_slice];
   assign w_slot   = w_nz_cur[SLICE_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FILL;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         pos_q       <= '0;
         comp_q      <= '0;
         inds_q      <= '0;
         nz_q        <= '0;
         tot_q       <= '0;
         flen_q      <= '0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (in_valid) begin
                  if (in_data != '0) begin
                     comp_q[w_slice][w_slot] <= in_data;
                     inds_q[w_slice][w_slot] <= pos_q;
                     nz_q[w_slice]           <= w_nz_cur + C_ONE;
                     tot_q                   <= tot_q + C_ONE;
                  end
                  pos_q  <= pos_q + C_ONE;
                  flen_q <= pos_q + C_ONE;
                  // Unreceived positions of an early-ended frame are simply
                  // never written, so they behave as zeros.
                  if (in_last || (pos_q == C_LASTPOS)) begin
                     state_q     <= S_HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               // Clearing the arrays here keeps unused slots reading zero
               // for the next frame without any per-slot valid tracking.
               if (out_ack) begin
                  state_q     <= S_FILL;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  pos_q       <= '0;
                  comp_q      <= '0;
                  inds_q      <= '0;
                  nz_q        <= '0;
                  tot_q       <= '0;
                  flen_q      <= '0;
               end
            end
            default: begin
               state_q     <= S_FILL;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = out_valid_q;
   assign compressed_ips  = comp_q;
   assign comp_inds_ips   = inds_q;
   assign nzips_per_slice = nz_q;
   assign num_nz_ips      = tot_q;
   assign frame_len       = flen_q;

   // Slice base indices are fixed by geometry and independent of reset.
   for (genvar s = 0; s < NUM_SLICES; s++) begin : g_offset
      assign offset_array[s] = IDX_W'(s * SLICE);
   end

endmodule
`default_nettype wire
